// File: rtl/comm_pkg.sv
// Shared byte-width constant, clog2 helper and parameter legality checks
// for the payload register file and its snapshot stage.
package comm_pkg;

  localparam int BYTE_W = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit out_bytes_ok(input int out_bytes, input int depth);
    return (out_bytes >= 1) && (out_bytes <= depth);
  endfunction

endpackage

// File: rtl/payload_snapshot.sv
// Payload output register: commit-captured snapshot with valid/ready
// handshake and overrun flag, or a free-running copy in live mode.
module payload_snapshot
  import comm_pkg::*;
#(
  parameter int OUT_BYTES = 6,
  parameter int LIVE_MODE = 0
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_L,
  input  logic [BYTE_W*OUT_BYTES-1:0] i_Low_Bytes,
  input  logic                        i_Commit,
  input  logic                        i_Ready,
  output logic [BYTE_W*OUT_BYTES-1:0] o_Data,
  output logic                        o_Valid,
  output logic                        o_Overrun
);

  logic live;
  assign live = (LIVE_MODE != 0);

  // A commit while a snapshot is still unaccepted replaces it; a
  // simultaneous ready means the old one left this cycle, so no overrun.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_Data    <= '0;
      o_Valid   <= 1'b0;
      o_Overrun <= 1'b0;
    end else if (live) begin
      o_Data    <= i_Low_Bytes;
      o_Valid   <= 1'b1;
      o_Overrun <= 1'b0;
    end else if (i_Commit) begin
      o_Data    <= i_Low_Bytes;
      o_Valid   <= 1'b1;
      o_Overrun <= o_Valid && !i_Ready;
    end else begin
      o_Overrun <= 1'b0;
      if (o_Valid && i_Ready) begin
        o_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/payload_regfile.sv
// Byte-wide payload register file: random and streaming write paths,
// registered read-back port and a handshaked snapshot of the low bytes.
module payload_regfile
  import comm_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int OUT_BYTES = 6,
  parameter  int LIVE_MODE = 0,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_L,
  input  logic                        i_Wr_En,
  input  logic [AW-1:0]               i_Wr_Addr,
  input  logic [BYTE_W-1:0]           i_Wr_Data,
  input  logic                        i_Strm_Start,
  input  logic                        i_Strm_Valid,
  input  logic [BYTE_W-1:0]           i_Strm_Data,
  output logic                        o_Strm_Wrap,
  input  logic [AW-1:0]               i_Rd_Addr,
  output logic [BYTE_W-1:0]           o_Rd_Data,
  input  logic                        i_Commit,
  output logic [BYTE_W*OUT_BYTES-1:0] o_Data,
  output logic                        o_Valid,
  input  logic                        i_Ready,
  output logic                        o_Overrun
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("payload_regfile: DEPTH must be a power of two >= 2");
  end
  if (!out_bytes_ok(OUT_BYTES, DEPTH)) begin : g_bad_out_bytes
    $error("payload_regfile: OUT_BYTES must be in 1..DEPTH");
  end

  logic [BYTE_W-1:0]           mem [DEPTH];
  logic [AW-1:0]               strm_ptr;
  logic [AW-1:0]               strm_addr;
  logic [AW-1:0]               strm_ptr_nxt;
  logic [BYTE_W*OUT_BYTES-1:0] low_bytes;

  // A start in the same cycle as a byte lands that byte at address 0.
  always_comb begin
    strm_addr    = i_Strm_Start ? '0 : strm_ptr;
    strm_ptr_nxt = strm_addr;
    if (i_Strm_Valid) begin
      strm_ptr_nxt = strm_addr + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      strm_ptr    <= '0;
      o_Strm_Wrap <= 1'b0;
    end else begin
      strm_ptr    <= strm_ptr_nxt;
      o_Strm_Wrap <= i_Strm_Valid && (strm_addr == AW'(DEPTH - 1));
    end
  end

  // Stream write is issued last so it wins an address collision.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (i_Wr_En) begin
        mem[i_Wr_Addr] <= i_Wr_Data;
      end
      if (i_Strm_Valid) begin
        mem[strm_addr] <= i_Strm_Data;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_Rd_Data <= '0;
    end else begin
      o_Rd_Data <= mem[i_Rd_Addr];
    end
  end

  always_comb begin
    low_bytes = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      low_bytes[i*BYTE_W +: BYTE_W] = mem[i];
    end
  end

  payload_snapshot #(
    .OUT_BYTES (OUT_BYTES),
    .LIVE_MODE (LIVE_MODE)
  ) u_snapshot (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Low_Bytes (low_bytes),
    .i_Commit    (i_Commit),
    .i_Ready     (i_Ready),
    .o_Data      (o_Data),
    .o_Valid     (o_Valid),
    .o_Overrun   (o_Overrun)
  );

endmodule

// File: tb/tb_payload_regfile.sv
// Bench for payload_regfile: snapshot and live instances share stimulus and
// are checked every cycle against a byte-array model plus directed literals.
module tb_payload_regfile;

  localparam int DEPTH = 16;
  localparam int OB    = 6;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          strm_start;
  logic          strm_valid;
  logic [7:0]    strm_data;
  logic [AW-1:0] rd_addr;
  logic          commit;
  logic          ready;

  logic          s_wrap, l_wrap;
  logic [7:0]    s_rd, l_rd;
  logic [47:0]   s_data, l_data;
  logic          s_valid, l_valid;
  logic          s_ovr, l_ovr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  payload_regfile #(.DEPTH(DEPTH), .OUT_BYTES(OB), .LIVE_MODE(0)) u_snap (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Wr_En(wr_en), .i_Wr_Addr(wr_addr),
    .i_Wr_Data(wr_data), .i_Strm_Start(strm_start), .i_Strm_Valid(strm_valid),
    .i_Strm_Data(strm_data), .o_Strm_Wrap(s_wrap), .i_Rd_Addr(rd_addr),
    .o_Rd_Data(s_rd), .i_Commit(commit), .o_Data(s_data), .o_Valid(s_valid),
    .i_Ready(ready), .o_Overrun(s_ovr)
  );

  payload_regfile #(.DEPTH(DEPTH), .OUT_BYTES(OB), .LIVE_MODE(1)) u_live (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Wr_En(wr_en), .i_Wr_Addr(wr_addr),
    .i_Wr_Data(wr_data), .i_Strm_Start(strm_start), .i_Strm_Valid(strm_valid),
    .i_Strm_Data(strm_data), .o_Strm_Wrap(l_wrap), .i_Rd_Addr(rd_addr),
    .o_Rd_Data(l_rd), .i_Commit(commit), .o_Data(l_data), .o_Valid(l_valid),
    .i_Ready(ready), .o_Overrun(l_ovr)
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte array, integer stream pointer, pending snapshot.
  byte unsigned m_mem [DEPTH];
  int           m_ptr;
  logic [47:0]  m_snap, m_live;
  bit           m_pend, m_ovr, m_wrap, m_lvalid, armed;
  byte unsigned m_rd;

  always @(posedge clk) begin
    if (!rst_l) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_ptr = 0; m_snap = '0; m_live = '0; m_pend = 0; m_ovr = 0;
      m_wrap = 0; m_lvalid = 0; m_rd = 0; armed = 1;
    end else if (armed) begin
      int sa;
      m_rd = m_mem[rd_addr];
      for (int i = 0; i < OB; i++) m_live[i*8 +: 8] = m_mem[i];
      m_lvalid = 1;
      if (commit) begin
        m_ovr  = m_pend && !ready;
        m_snap = m_live;
        m_pend = 1;
      end else begin
        m_ovr = 0;
        if (m_pend && ready) m_pend = 0;
      end
      sa = strm_start ? 0 : m_ptr;
      m_wrap = strm_valid && (sa == DEPTH - 1);
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (strm_valid) begin
        m_mem[sa] = strm_data;
        m_ptr = (sa + 1) % DEPTH;
      end else begin
        m_ptr = sa;
      end
    end
    #1;
    if (armed) begin
      chk("snap_rd",    {40'd0, s_rd},    {40'd0, m_rd});
      chk("snap_wrap",  {47'd0, s_wrap},  {47'd0, m_wrap});
      chk("snap_data",  s_data,           m_snap);
      chk("snap_valid", {47'd0, s_valid}, {47'd0, m_pend});
      chk("snap_ovr",   {47'd0, s_ovr},   {47'd0, m_ovr});
      chk("live_rd",    {40'd0, l_rd},    {40'd0, m_rd});
      chk("live_wrap",  {47'd0, l_wrap},  {47'd0, m_wrap});
      chk("live_data",  l_data,           m_live);
      chk("live_valid", {47'd0, l_valid}, {47'd0, m_lvalid});
      chk("live_ovr",   {47'd0, l_ovr},   48'd0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    chk(name, {40'd0, s_rd}, {40'd0, exp});
  endtask

  initial begin
    armed = 0;
    rst_l = 1'b0; wr_en = 0; wr_addr = '0; wr_data = '0;
    strm_start = 0; strm_valid = 0; strm_data = '0;
    rd_addr = '0; commit = 0; ready = 0;
    tick(2);
    chk("reset_valid", {47'd0, s_valid}, 48'd0);
    chk("reset_data",  s_data, 48'd0);
    rst_l = 1'b1;

    // random writes then commit
    for (int i = 0; i < 6; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = 8'(8'h11 * (i + 1));
      tick();
    end
    wr_en = 0;
    commit = 1; tick(); commit = 0;
    chk("commit_valid", {47'd0, s_valid}, 48'd1);
    chk("commit_data",  s_data, 48'h665544332211);
    ready = 1; tick(); ready = 0;
    chk("accept_valid", {47'd0, s_valid}, 48'd0);

    // stream 17 bytes through a wrap
    for (int i = 0; i < 17; i++) begin
      strm_start = (i == 0); strm_valid = 1; strm_data = 8'(i);
      tick();
      chk("strm_wrap", {47'd0, s_wrap}, {47'd0, (i == 15)});
    end
    strm_start = 0; strm_valid = 0;
    tick();
    chk("wrap_single", {47'd0, s_wrap}, 48'd0);
    rd_check("rd_addr15", 4'd15, 8'h0F);
    rd_check("rd_addr0",  4'd0,  8'h10);
    strm_valid = 1; strm_data = 8'hEE; tick(); strm_valid = 0;
    rd_check("ptr_was_1", 4'd1, 8'hEE);

    // overrun: two commits without ready
    wr_en = 1; wr_addr = 0; wr_data = 8'h11; tick(); wr_en = 0;
    commit = 1; tick(); commit = 0;
    wr_en = 1; wr_addr = 0; wr_data = 8'h77; tick(); wr_en = 0;
    commit = 1; tick(); commit = 0;
    chk("ovr_pulse",  {47'd0, s_ovr},   48'd1);
    chk("ovr_byte0",  {40'd0, s_data[7:0]}, 48'h77);
    chk("ovr_valid",  {47'd0, s_valid}, 48'd1);
    tick();
    chk("ovr_single", {47'd0, s_ovr},   48'd0);
    chk("ovr_hold",   {47'd0, s_valid}, 48'd1);

    // commit with ready while valid: back-to-back transfer
    wr_en = 1; wr_addr = 0; wr_data = 8'h99; tick(); wr_en = 0;
    commit = 1; ready = 1; tick(); commit = 0;
    chk("b2b_ovr",   {47'd0, s_ovr},   48'd0);
    chk("b2b_valid", {47'd0, s_valid}, 48'd1);
    chk("b2b_byte0", {40'd0, s_data[7:0]}, 48'h99);
    tick(); ready = 0;
    chk("b2b_drain", {47'd0, s_valid}, 48'd0);

    // same-cycle random + stream writes
    strm_start = 1; strm_valid = 1; strm_data = 8'h01; tick(); strm_start = 0;
    strm_data = 8'h02; tick();
    strm_data = 8'h03; tick();
    strm_data = 8'h55; wr_en = 1; wr_addr = 3; wr_data = 8'hAA; tick();
    strm_data = 8'h66; wr_addr = 9; wr_data = 8'hBB; tick();
    strm_valid = 0; wr_en = 0;
    rd_check("collide_3", 4'd3, 8'h55);
    rd_check("split_4",   4'd4, 8'h66);
    rd_check("split_9",   4'd9, 8'hBB);

    // live mode: visible two edges after the write, no commit
    wr_en = 1; wr_addr = 2; wr_data = 8'h5A; tick(); wr_en = 0;
    chk("live_old",  {40'd0, l_data[23:16]}, 48'h03);
    tick();
    chk("live_new",  {40'd0, l_data[23:16]}, 48'h5A);

    // reset mid-stream
    strm_valid = 1; strm_data = 8'h21; tick();
    strm_data = 8'h22; rst_l = 0; tick();
    chk("rst_live_data",  l_data, 48'd0);
    chk("rst_live_valid", {47'd0, l_valid}, 48'd0);
    chk("rst_snap_valid", {47'd0, s_valid}, 48'd0);
    rst_l = 1; strm_data = 8'hC3; tick(); strm_valid = 0;
    chk("live_valid_up", {47'd0, l_valid}, 48'd1);
    rd_check("rst_ptr0", 4'd0, 8'hC3);
    rd_check("rst_mem5", 4'd5, 8'h00);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
